// File: rtl/board_disp_sched_if.sv
// Link between the display scheduler and the shared parallel-to-serial engine.
// The master side drives data, start and chain-select; the engine reports busy/finish.
interface board_disp_sched_if;
    logic        p2s_start;
    logic        p2s_busy;
    logic        p2s_finish;
    logic        p2s_sel;
    logic [63:0] p2s_data;

    modport master (
        output p2s_start,
        output p2s_sel,
        output p2s_data,
        input  p2s_busy,
        input  p2s_finish
    );

    modport slave (
        input  p2s_start,
        input  p2s_sel,
        input  p2s_data,
        output p2s_busy,
        output p2s_finish
    );
endinterface

// File: rtl/board_disp_sched.sv
// Shares one P2S shift engine between the 16-bit LED chain and the 64-bit 7-segment chain,
// resending a chain on data change, periodic refresh tick or forced refresh.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | no frame in flight; arbitrate pending chains (round-robin)
// S_START | one-cycle start pulse to the engine, watchdog cleared
// S_WAIT  | waiting for engine finish, watchdog running
module board_disp_sched #(
    parameter int unsigned CLK_FREQ    = 100,
    parameter int unsigned REFRESH_MS  = 100,
    parameter int unsigned TIMEOUT_CYC = 10000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [15:0]                led,
    input  logic [63:0]                seg,
    input  logic                       force_req,
    board_disp_sched_if.master         eng,
    output logic                       done_led,
    output logic                       done_seg,
    output logic                       timeout
);

    localparam int unsigned REF_N    = CLK_FREQ * REFRESH_MS * 1000;
    localparam int unsigned REF_W    = (REF_N > 1) ? $clog2(REF_N) : 1;
    localparam int unsigned WD_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REF_N - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

    state_t            state, state_nxt;
    logic [REF_W-1:0]  ref_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic [15:0]       sent_led;
    logic [63:0]       sent_seg;
    logic              pend_led_r, pend_seg_r;
    logic              last_grant;
    logic              tick, refresh;
    logic              req_led, req_seg;
    logic              grant_led, grant_seg;
    logic              wd_hit;
    logic              unused_busy;

    // Busy is informational only; sequencing relies solely on finish.
    assign unused_busy = eng.p2s_busy;

    assign tick    = (ref_cnt == REF_LAST);
    assign refresh = tick | force_req;
    assign req_led = pend_led_r | (led != sent_led);
    assign req_seg = pend_seg_r | (seg != sent_seg);
    assign wd_hit  = (state == S_WAIT) && !eng.p2s_finish && (wd_cnt == WD_LAST);

    always_comb begin
        grant_led = 1'b0;
        grant_seg = 1'b0;
        if (state == S_IDLE) begin
            if (req_led && req_seg) begin
                if (last_grant) grant_led = 1'b1;
                else            grant_seg = 1'b1;
            end else if (req_led) begin
                grant_led = 1'b1;
            end else if (req_seg) begin
                grant_seg = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_led || grant_seg) state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT:  if (eng.p2s_finish || wd_hit) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        eng.p2s_start = (state == S_START);
        timeout       = wd_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt      <= '0;
            wd_cnt       <= '0;
            sent_led     <= '0;
            sent_seg     <= '0;
            pend_led_r   <= 1'b1;
            pend_seg_r   <= 1'b1;
            last_grant   <= 1'b1;
            eng.p2s_sel  <= 1'b0;
            eng.p2s_data <= '0;
            done_led     <= 1'b0;
            done_seg     <= 1'b0;
        end else begin
            ref_cnt  <= tick ? '0 : ref_cnt + 1'b1;
            done_led <= (state == S_WAIT) && eng.p2s_finish && !eng.p2s_sel;
            done_seg <= (state == S_WAIT) && eng.p2s_finish &&  eng.p2s_sel;

            if (state == S_START)     wd_cnt <= '0;
            else if (state == S_WAIT) wd_cnt <= wd_cnt + 1'b1;

            if (grant_led) begin
                sent_led     <= led;
                eng.p2s_data <= {48'b0, led};
                eng.p2s_sel  <= 1'b0;
                last_grant   <= 1'b0;
            end else if (grant_seg) begin
                sent_seg     <= seg;
                eng.p2s_data <= seg;
                eng.p2s_sel  <= 1'b1;
                last_grant   <= 1'b1;
            end

            // Refresh outranks the clear from a same-cycle grant; an aborted frame re-queues its chain.
            if (refresh)                        pend_led_r <= 1'b1;
            else if (grant_led)                 pend_led_r <= 1'b0;
            else if (wd_hit && !eng.p2s_sel)    pend_led_r <= 1'b1;

            if (refresh)                        pend_seg_r <= 1'b1;
            else if (grant_seg)                 pend_seg_r <= 1'b0;
            else if (wd_hit && eng.p2s_sel)     pend_seg_r <= 1'b1;
        end
    end

endmodule

// File: doc/board_disp_sched.md
Name: board_disp_sched

Overview:
- Scheduler that shares one parallel-to-serial shift engine (start/busy/finish handshake) between two board display chains: the 16-bit LED chain and the 64-bit 7-segment chain.
- Sends a frame to a chain when its data changes, on a periodic refresh tick, or on a forced refresh.
- Sits between the display data sources and a single P2S instance.
- Drives the engine's data, start and chain-select; downstream muxing of s_clk/s_clr/s_dat uses p2s_sel.

Parameters:
- CLK_FREQ, 100: main clock frequency in MHz.
- REFRESH_MS, 100: periodic refresh interval in ms. Refresh period N = CLK_FREQ*REFRESH_MS*1000 cycles.
- TIMEOUT_CYC, 10000: maximum cycles to wait for p2s_finish after start.

Ports:
- clk  in  1  main clock.
- rst_n  in  1  asynchronous active-low reset.
- led  in  16  LED frame to display.
- seg  in  64  segment frame to display.
- force  in  1  single-cycle pulse: refresh both chains.
- p2s_start  out  1  one-cycle start pulse to the engine.
- p2s_busy  in  1  engine busy (status only; not used for sequencing).
- p2s_finish  in  1  one-cycle pulse when the engine completes a frame.
- p2s_sel  out  1  chain being served: 0 = LED, 1 = SEG.
- p2s_data  out  64  frame to the engine. For LED: {48'b0, led}. Held stable from grant until return to IDLE.
- done_led  out  1  one-cycle pulse when an LED frame completes.
- done_seg  out  1  one-cycle pulse when a SEG frame completes.
- timeout  out  1  one-cycle pulse when a frame is aborted by the watchdog.

Behaviour:
- Reset (async, rst_n=0) clears:
  - all outputs to 0;
  - sent_led=0, sent_seg=0, refresh counter=0, watchdog=0, state=IDLE;
  - last_grant=SEG.
  - pend_led_r and pend_seg_r are set to 1, so both chains are written after reset.
- Refresh counter:
  - counts 0..N-1, then wraps to 0;
  - tick is asserted in the cycle the count equals N-1;
  - tick or force sets pend_led_r and pend_seg_r; set has priority over a same-cycle clear.
- Pending status:
  - req_led = pend_led_r | (led != sent_led);
  - req_seg = pend_seg_r | (seg != sent_seg).
- FSM states: IDLE, START, WAIT.
  - IDLE, no request: stay in IDLE.
  - IDLE, one request: grant that chain.
  - IDLE, both requests: grant the chain not equal to last_grant (round-robin).
  - Grant cycle:
    - sent_x <= input and p2s_data <= input;
    - p2s_sel <= chain, last_grant <= chain;
    - pend_x_r cleared unless tick/force occurs in the same cycle;
    - next state START.
  - START: p2s_start=1 for exactly this one cycle; watchdog <= 0; next state WAIT.
  - WAIT:
    - p2s_finish=1: pulse done_led or done_seg per p2s_sel next cycle; go to IDLE.
    - watchdog reaches TIMEOUT_CYC-1 with no finish: pulse timeout, set pend_x_r of the served chain, go to IDLE.
    - finish and timeout in the same cycle: finish wins.
- Grant-to-start latency: 1 cycle after the grant decision. A new grant is possible in the cycle after return to IDLE.
- Input changes during START/WAIT do not alter p2s_data. They are detected afterwards via the mismatch against sent_x.
- A tick during a frame re-queues both chains, including the one being served.
- p2s_finish outside WAIT is ignored.
- Reset mid-frame: outputs drop immediately; both chains are re-queued on release.

Test Plan:
- CLK_FREQ=1, REFRESH_MS=1 (N=1000), finish stub 10 cycles after start. Release reset:
  - LED granted first: p2s_data=0x0000_0000_0000_0000 (led=0), sel=0, start at cycle 2;
  - done_led, then SEG granted with sel=1;
  - idle until cycle 999 tick, then LED and SEG are sent again.
- Idle with led=0x00FF; change led to 0xA5A5:
  - one grant, p2s_data=0x...A5A5, start pulse exactly 1 cycle wide, done_led after finish;
  - no further frame until the next tick.
- Both led and seg change in the same cycle with last_grant=LED:
  - SEG served first, then LED;
  - exactly two start pulses.
- Change seg from 0x1 to 0x2 while an LED frame is in WAIT:
  - LED frame data unchanged;
  - seg=0x2 is sent after LED completes.
- Finish never asserted, TIMEOUT_CYC=50:
  - timeout pulse 50 cycles after start;
  - the same chain is re-granted next and p2s_start fires again.
- rst_n low during WAIT: all outputs 0 asynchronously. After release, both chains are re-sent LED then SEG.
- force pulse while idle: LED and SEG both re-sent even with unchanged data.
